// File: rtl/sensor_scan_scheduler.sv
// Round-robin arbiter sharing one co_processor between four sensor channels.
// Define ALERT_STICKY_EN for alerts that latch until alert_clr.
module sensor_scan_scheduler #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] ch_data,
  output logic [3:0]  ack,
  output logic [7:0]  cp_r0,
  output logic [1:0]  cp_check,
  input  logic        cp_q,
  input  logic [1:0]  cp_q1,
  input  logic [3:0]  alert_clr,
  output logic [3:0]  alert,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [1:0] last;
  logic [1:0] pick;
  logic       found;
  logic       smp;
  logic       hit;
  logic [3:0] gsel;

  // first requester after the last grant, wrapping mod 4
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last + 2'(k)]) begin
        pick  = last + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = DRIVE;
      DRIVE:   if (cnt == 4'd0) state_nx = SAMPLE;
      SAMPLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    smp  = (state == SAMPLE);
    busy = (state != IDLE);
    gsel = 4'b0001 << cp_check;
    ack  = smp ? gsel : 4'b0000;
    hit  = cp_q & (cp_q1 == cp_check);
  end

  // cp_check doubles as the grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 4'd0;
      last     <= 2'd3;
      cp_r0    <= 8'h00;
      cp_check <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            cp_r0    <= ch_data[{pick, 3'b000} +: 8];
            cp_check <= pick;
            cnt      <= 4'(SETTLE - 1);
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        SAMPLE:  last <= cp_check;
        default: ;
      endcase
    end
  end

`ifdef ALERT_STICKY_EN
  // clear first so a same-cycle hit wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alert <= 4'b0000;
    else alert <= (alert & ~alert_clr) | ({4{smp & hit}} & gsel);
  end
`else
  logic unused_clr;
  assign unused_clr = ^alert_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   alert           <= 4'b0000;
    else if (smp) alert[cp_check] <= hit;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |alert;
  end

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Scoreboard bench for sensor_scan_scheduler with a transaction-level model.
// Co-processor stand-in: Q = r0[4], Q1 = r0[6:5].
module tb_sensor_scan_scheduler;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] ch_data;
  logic [3:0]  ack;
  logic [7:0]  cp_r0;
  logic [1:0]  cp_check;
  logic        cp_q;
  logic [1:0]  cp_q1;
  logic [3:0]  alert_clr;
  logic [3:0]  alert;
  logic        busy;
  logic        irq;

  sensor_scan_scheduler #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ch_data(ch_data),
    .ack(ack), .cp_r0(cp_r0), .cp_check(cp_check),
    .cp_q(cp_q), .cp_q1(cp_q1), .alert_clr(alert_clr),
    .alert(alert), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  assign cp_q  = cp_r0[4];
  assign cp_q1 = cp_r0[6:5];

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         cyc;
  } txn_t;

  txn_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_ack = 0;

  bit         act;
  int         g_cyc;
  int         g_ch;
  logic [7:0] g_data;
  bit         g_hit;
  int         next_ok;
  int         mlast;
  logic [3:0] alert_m;
  bit         irq_m;
  logic [7:0] r0_m;
  logic [1:0] chk_m;
  logic [3:0] acked;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h cycle %0d", nm, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    act = 0; next_ok = 0; mlast = 3;
    alert_m = 4'b0; irq_m = 0;
    r0_m = 8'h00; chk_m = 2'd0;
    acked = 4'b0;
    sb.delete();
  endtask

  // reference model: one grant per S+2 cycles, round robin from mlast
  always @(posedge clk) begin
    int c;
    cyc++;
    if (rst_n === 1'b1) begin
      irq_m = |alert_m;
`ifdef ALERT_STICKY_EN
      alert_m = alert_m & ~alert_clr;
`endif
      if (act && cyc == g_cyc + S + 1) begin
`ifdef ALERT_STICKY_EN
        if (g_hit) alert_m[g_ch] = 1'b1;
`else
        alert_m[g_ch] = g_hit;
`endif
        act = 0;
      end
      if (!act && cyc >= next_ok && req != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          c = (mlast + k) % 4;
          if (req[c]) begin
            g_ch = c;
            break;
          end
        end
        g_data = ch_data[8*g_ch +: 8];
        g_hit = g_data[4] && (g_data[6:5] == g_ch[1:0]);
        g_cyc = cyc;
        act = 1;
        next_ok = cyc + S + 2;
        mlast = g_ch;
        r0_m = g_data;
        chk_m = g_ch[1:0];
        sb.push_back('{g_ch, g_data, cyc + S});
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [3:0] ea;
    txn_t t;
    ea = (act && cyc == g_cyc + S) ? (4'b0001 << g_ch) : 4'b0;
    chk("ack", ack, ea);
    chk("busy", busy, act);
    chk("cp_r0", cp_r0, r0_m);
    chk("cp_check", cp_check, chk_m);
    chk("alert", alert, alert_m);
    chk("irq", irq, irq_m);
    if (ack != 4'b0) begin
      n_ack++;
      acked = acked | ack;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got ack %0h want none", ack);
      end else begin
        t = sb.pop_front();
        chk("sb_ack", ack, 4'b0001 << t.ch);
        chk("sb_data", cp_r0, t.data);
        chk("sb_cyc", cyc, t.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(int ch, logic [7:0] d, logic [3:0] clr);
    int n;
    n = 0;
    req[ch] = 1'b1;
    ch_data[8*ch +: 8] = d;
    alert_clr = clr;
    acked[ch] = 1'b0;
    while (!acked[ch] && n < 100) begin
      step();
      n++;
    end
    chk("serve_ack", acked[ch], 1'b1);
    req[ch] = 1'b0;
    alert_clr = 4'b0;
    acked[ch] = 1'b0;
  endtask

  initial begin
    int n;
    int start;
    model_reset();
    rst_n = 1'b0;
    req = 4'b0;
    ch_data = 32'h0;
    alert_clr = 4'b0;
    repeat (5) begin
      step();
      req = 4'($urandom);
      ch_data = $urandom;
      alert_clr = 4'($urandom);
    end
    req = 4'b0;
    alert_clr = 4'b0;
    rst_n = 1'b1;
    repeat (20) step();

    serve(0, 8'h10, 4'b0);
    repeat (3) step();

    ch_data = 32'h53_72_31_10;
    req = 4'b1111;
    start = n_ack;
    n = 0;
    while (n_ack - start < 5 && n < 100) begin
      step();
      n++;
    end
    chk("rr_count", n_ack - start, 5);
    req = 4'b0;
    repeat (S + 4) step();

    serve(2, 8'h30, 4'b0);
    repeat (3) step();

    serve(1, 8'h30, 4'b0);
    repeat (3) step();
    serve(1, 8'h00, 4'b0);
    repeat (3) step();
    alert_clr = 4'b0010;
    step();
    alert_clr = 4'b0;
    repeat (2) step();
    serve(1, 8'h30, 4'b0010);
    repeat (3) step();

    req = 4'b0001;
    ch_data[7:0] = 8'h10;
    n = 0;
    while (!act && n < 20) begin
      step();
      n++;
    end
    repeat (2) step();
    rst_n = 1'b0;
    model_reset();
    req = 4'b0100;
    ch_data[23:16] = 8'h50;
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    while (acked == 4'b0 && n < 50) begin
      step();
      n++;
    end
    chk("rst_first", acked, 4'b0100);
    req = 4'b0;
    acked = 4'b0;
    repeat (S + 4) step();

    repeat (3000) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (req[i] && acked[i]) begin
          acked[i] = 1'b0;
          if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        end else if (req[i] && $urandom_range(63, 0) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          ch_data[8*i +: 8] = 8'($urandom);
          acked[i] = 1'b0;
          req[i] = 1'b1;
        end
      end
      alert_clr = ($urandom_range(7, 0) == 0) ? 4'($urandom) : 4'b0;
    end
    req = 4'b0;
    alert_clr = 4'b0;
    repeat (S + 6) step();
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_scan_scheduler.md
# sensor_scan_scheduler

Round-robin scheduler that shares one `co_processor` comparison datapath between four sensor channels. Each channel raises a request with an 8-bit sample. The scheduler grants one channel at a time and drives the sample and channel index into the co-processor. It waits a fixed settle window for the co-processor pipeline, then samples the alert outputs, records a per-channel alert and acknowledges the requester. It sits between the sensor front-ends and `co_processor`, and feeds the top-level interrupt/LED logic.

## Interface
Parameters:
- `SETTLE`, default 4: cycles the co-processor inputs are held before sampling `cp_q`/`cp_q1`; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  4  per-channel request; bit i = channel i.
- `ch_data`  in  32  channel samples; channel i on bits [8i+7:8i]; stable while `req[i]`=1 until `ack[i]`.
- `ack`  out  4  one-cycle pulse to the granted channel at transaction end.
- `cp_r0`  out  8  sample driven to `co_processor.r0`.
- `cp_check`  out  2  channel index driven to `co_processor.check`.
- `cp_q`  in  1  `co_processor.Q`.
- `cp_q1`  in  2  `co_processor.Q1`.
- `alert_clr`  in  4  per-channel alert clear.
- `alert`  out  4  per-channel alert flags.
- `busy`  out  1  high while a transaction is in progress (DRIVE or SAMPLE).
- `irq`  out  1  OR of `alert`, registered.

## Operation
- Reset values:
  - `ack`=0, `cp_r0`=0x00, `cp_check`=0, `alert`=0, `busy`=0, `irq`=0.
  - State IDLE; last-grant pointer `last`=3, so channel 0 wins first.
- FSM states: IDLE, DRIVE, SAMPLE.
- IDLE:
  - If `req`≠0, select the first set bit searching `last+1, last+2, …` (mod 4).
  - Load `cp_r0`←that channel's `ch_data` byte, `cp_check`←its index, settle counter←`SETTLE`-1; go to DRIVE.
  - If `req`=0, stay in IDLE.
- DRIVE: hold `cp_r0`/`cp_check`. Decrement the counter; at 0 go to SAMPLE. DRIVE lasts exactly `SETTLE` cycles.
- SAMPLE (one cycle):
  - hit = `cp_q` & (`cp_q1` == grant index).
  - Update `alert[grant]` (see Configuration).
  - `ack[grant]`=1, `last`←grant; go to IDLE.
- Fairness: a requester holding `req` high continuously is served at most once every four grants when all four request.
- `cp_r0`/`cp_check` retain their last values in IDLE. The co-processor sees a stable channel index between transactions.
- `req[i]` dropped mid-transaction: the transaction completes and `ack[i]` still pulses. `ch_data` is sampled only at grant.
- `req` bits that change during DRIVE/SAMPLE are ignored until the next IDLE.
- `irq` = registered OR of `alert`, updated every cycle.
- Asynchronous `rst_n` assertion mid-transaction: immediately returns all registers to reset values. No `ack` is issued for the aborted transaction.

## Timing
- `req` sampled high in IDLE at edge N → `busy`=1 and `cp_r0`/`cp_check` valid from N+1.
- `ack` high during cycle N+1+`SETTLE`; back in IDLE at N+2+`SETTLE`.
- `alert` update visible at N+2+`SETTLE`; `irq` one cycle later.
- Back-to-back throughput: one transaction per `SETTLE`+2 cycles.
- `busy` falls in the same cycle the FSM enters IDLE.

## Configuration
- `ALERT_STICKY_EN` defined:
  - `alert[i]` is set by a hit and held until `alert_clr[i]`=1; a miss does not clear it.
  - Hit and clear in the same cycle on the same channel: the set wins.
- `ALERT_STICKY_EN` undefined:
  - `alert[i]` is overwritten with hit on every SAMPLE of channel i.
  - `alert_clr` is ignored.

## Test plan
- Reset: drive `rst_n`=0 with random inputs → all outputs 0; after release with `req`=0, `busy` stays 0 for 20 cycles.
- Single request: `req`=0001, `ch_data[7:0]`=0x10, bench model drives `cp_q`=1 and `cp_q1`=00 → `cp_r0`=0x10 and `cp_check`=0 one cycle after the request; `ack`=0001 exactly `SETTLE`+1 cycles after the request; `alert`=0001, `irq`=1 a cycle later.
- Round robin: `req`=1111 held → grant order 0,1,2,3,0 with `cp_check` sequence 0,1,2,3,0; `ack` pulses spaced `SETTLE`+2 cycles apart.
- Mismatched index: channel 2 granted, `cp_q`=1, `cp_q1`=01 → `alert[2]` stays 0.
- Sticky/clear (with `ALERT_STICKY_EN`):
  - Hit on channel 1, then a miss → `alert[1]` stays 1.
  - `alert_clr`=0010 → `alert[1]`=0.
  - Hit and clear in the same cycle → `alert[1]`=1.
  - Without the macro, the miss clears `alert[1]`.
- Reset mid-DRIVE: assert `rst_n`=0 two cycles into DRIVE → no `ack`, outputs reset; after release, pending `req`=0100 is granted first.
